// File: rtl/fpadd_arbiter.sv
// Round-robin front end sharing one non-pipelined FP adder among NUM_REQ requesters.
// One op in flight; each result is held on RspValid until the granted requester takes it.
module fpadd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_REQ-1:0]    ReqValid_i,
  input  logic [32*NUM_REQ-1:0] ReqOp1_i,
  input  logic [32*NUM_REQ-1:0] ReqOp2_i,
  output logic [NUM_REQ-1:0]    ReqReady_o,
  output logic [NUM_REQ-1:0]    RspValid_o,
  input  logic [NUM_REQ-1:0]    RspReady_i,
  output logic [31:0]           RspResult_o,
  output logic                  ErrTimeout_o,
  output logic                  ArbBusy_o,
  output logic [31:0]           AddOp1_o,
  output logic [31:0]           AddOp2_o,
  output logic                  AddInputValid_o,
  input  logic                  AddBusy_i,
  input  logic [31:0]           AddResult_i,
  input  logic                  AddResultValid_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = IW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [31:0]   QNAN = 32'h7FC0_0000;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, grant_q, grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic          err_q, err_d;
  logic          accept;

  logic [31:0] op1_arr [NUM_REQ];
  logic [31:0] op2_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op1_arr[i] = ReqOp1_i[32*i +: 32];
    assign op2_arr[i] = ReqOp2_i[32*i +: 32];
  end

  // Rotate requests so bit 0 is the rr pointer; the lowest set bit wins.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 pick_vld;
  logic [IW-1:0]        pick_off, pick;
  logic [SW-1:0]        pick_sum;

  assign req_dbl = {ReqValid_i, ReqValid_i} >> rr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = IW'(k);
      end
    end
  end

  assign pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
  assign pick     = (pick_sum >= SW'(NUM_REQ)) ? IW'(pick_sum - SW'(NUM_REQ)) : IW'(pick_sum);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld && !AddBusy_i) begin
          accept  = 1'b1;
          grant_d = pick;
          op1_d   = op1_arr[pick];
          op2_d   = op2_arr[pick];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A valid flag in the first WAIT cycle may be left over from before the start pulse.
        if (timer_q != '0 && AddResultValid_i && !AddBusy_i) begin
          res_d   = AddResult_i;
          state_d = S_DELIVER;
        end else if (timer_q == TMAX) begin
          res_d   = QNAN;
          err_d   = 1'b1;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (RspReady_i[grant_q]) begin
          rr_d    = (grant_q == LAST) ? '0 : grant_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      timer_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign ReqReady_o      = accept ? (NUM_REQ'(1) << pick) : '0;
  assign RspValid_o      = (state_q == S_DELIVER) ? (NUM_REQ'(1) << grant_q) : '0;
  assign RspResult_o     = res_q;
  assign ErrTimeout_o    = err_q;
  assign ArbBusy_o       = (state_q != S_IDLE);
  assign AddOp1_o        = op1_q;
  assign AddOp2_o        = op2_q;
  assign AddInputValid_o = (state_q == S_ISSUE);

endmodule
